// File: rtl/dmem_arbiter.sv
// Two-port arbiter for the single-cycle data memory: round-robin between the core (r0) and the
// debug/loader port (r1), optional locked sequences, out-of-range rejection, registered responses.
module dmem_arbiter #(
    parameter int unsigned ADDR_WORDS = 8184,
    parameter bit          RESET_PRIO = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        r0_valid,
    output logic        r0_ready,
    input  logic [31:0] r0_addr,
    input  logic [31:0] r0_wdata,
    input  logic [3:0]  r0_wmask,
    input  logic        r0_lock,
    output logic        r0_rsp_valid,
    output logic [31:0] r0_rsp_rdata,
    output logic        r0_rsp_err,
    input  logic        r1_valid,
    output logic        r1_ready,
    input  logic [31:0] r1_addr,
    input  logic [31:0] r1_wdata,
    input  logic [3:0]  r1_wmask,
    input  logic        r1_lock,
    output logic        r1_rsp_valid,
    output logic [31:0] r1_rsp_rdata,
    output logic        r1_rsp_err,
    output logic [3:0]  mem_wmask,
    output logic [31:0] mem_a,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd,
    output logic [1:0]  dbg_state
);
    // Handshake: an access is accepted on the rising edge where rN_valid and rN_ready are both high.
    // rN_ready is combinational, never high without rN_valid, and at most one ready is high per cycle.
    // Responses are single-cycle pulses one cycle after acceptance and cannot be back-pressured.

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } state_t;

    localparam logic [31:0] WORD_LIMIT = ADDR_WORDS;

    state_t state_q, state_d;
    logic   rr_q, rr_d;
    logic   g0, g1;
    logic   in_range0, in_range1;

    assign in_range0 = ({2'b00, r0_addr[31:2]} < WORD_LIMIT);
    assign in_range1 = ({2'b00, r1_addr[31:2]} < WORD_LIMIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rr_q    <= RESET_PRIO;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
        end
    end

    always_comb begin
        g0      = 1'b0;
        g1      = 1'b0;
        state_d = state_q;
        rr_d    = rr_q;
        case (state_q)
            IDLE: begin
                g0 = r0_valid && (!r1_valid || !rr_q);
                g1 = r1_valid && (!r0_valid || rr_q);
            end
            LOCK0:   g0 = r0_valid;
            LOCK1:   g1 = r1_valid;
            default: state_d = IDLE;
        endcase
        // An out-of-range access never takes or keeps a lock.
        if (g0) begin
            if (r0_lock && in_range0) begin
                state_d = LOCK0;
            end else begin
                state_d = IDLE;
                rr_d    = 1'b1;
            end
        end else if (g1) begin
            if (r1_lock && in_range1) begin
                state_d = LOCK1;
            end else begin
                state_d = IDLE;
                rr_d    = 1'b0;
            end
        end
    end

    assign r0_ready  = g0;
    assign r1_ready  = g1;
    assign dbg_state = state_q;

    always_comb begin
        mem_a     = 32'd0;
        mem_wd    = 32'd0;
        mem_wmask = 4'd0;
        if (g0) begin
            mem_a     = r0_addr;
            mem_wd    = r0_wdata;
            mem_wmask = in_range0 ? r0_wmask : 4'd0;
        end else if (g1) begin
            mem_a     = r1_addr;
            mem_wd    = r1_wdata;
            mem_wmask = in_range1 ? r1_wmask : 4'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r0_rsp_valid <= 1'b0;
            r0_rsp_rdata <= 32'd0;
            r0_rsp_err   <= 1'b0;
            r1_rsp_valid <= 1'b0;
            r1_rsp_rdata <= 32'd0;
            r1_rsp_err   <= 1'b0;
        end else begin
            r0_rsp_valid <= g0;
            r0_rsp_err   <= g0 && !in_range0;
            r0_rsp_rdata <= (g0 && in_range0 && (r0_wmask == 4'd0)) ? mem_rd : 32'd0;
            r1_rsp_valid <= g1;
            r1_rsp_err   <= g1 && !in_range1;
            r1_rsp_rdata <= (g1 && in_range1 && (r1_wmask == 4'd0)) ? mem_rd : 32'd0;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a byte-maskable memory model, per-port expected-response queues
// filled by the drivers and drained by a monitor whenever a response pulse appears.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        r0_valid, r0_ready, r0_lock, r0_rsp_valid, r0_rsp_err;
    logic [31:0] r0_addr, r0_wdata, r0_rsp_rdata;
    logic [3:0]  r0_wmask;
    logic        r1_valid, r1_ready, r1_lock, r1_rsp_valid, r1_rsp_err;
    logic [31:0] r1_addr, r1_wdata, r1_rsp_rdata;
    logic [3:0]  r1_wmask;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_a, mem_wd, mem_rd;
    logic [1:0]  dbg_state;

    int tests = 0;
    int fails = 0;
    int cycle = 0;

    logic [32:0] exp_q0[$];
    logic [32:0] exp_q1[$];
    int          cyc_q0[$];
    int          cyc_q1[$];
    int          grant_log[$];
    bit          log_en = 1'b0;

    logic [31:0] mem [0:8191];

    dmem_arbiter #(.ADDR_WORDS(8184), .RESET_PRIO(1'b0)) dut (
        .clk(clk), .rst_n(rst_n),
        .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
        .r0_wmask(r0_wmask), .r0_lock(r0_lock), .r0_rsp_valid(r0_rsp_valid),
        .r0_rsp_rdata(r0_rsp_rdata), .r0_rsp_err(r0_rsp_err),
        .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
        .r1_wmask(r1_wmask), .r1_lock(r1_lock), .r1_rsp_valid(r1_rsp_valid),
        .r1_rsp_rdata(r1_rsp_rdata), .r1_rsp_err(r1_rsp_err),
        .mem_wmask(mem_wmask), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd),
        .dbg_state(dbg_state)
    );

    // Clock / reset / memory model
    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    assign mem_rd = mem[mem_a[14:2]];
    always @(posedge clk) begin
        for (int b = 0; b < 4; b++)
            if (mem_wmask[b]) mem[mem_a[14:2]][8*b +: 8] <= mem_wd[8*b +: 8];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        logic [32:0] e;
        int          c;
        if (rst_n) begin
            check("one_ready", {31'd0, r0_ready & r1_ready}, 32'd0);
            check("r0_ready_wo_valid", {31'd0, r0_ready & ~r0_valid}, 32'd0);
            check("r1_ready_wo_valid", {31'd0, r1_ready & ~r1_valid}, 32'd0);
            if (log_en && r0_ready) grant_log.push_back(0);
            if (log_en && r1_ready) grant_log.push_back(1);
            if (r0_rsp_valid) begin
                if (exp_q0.size() == 0) begin
                    check("r0_unexpected_rsp", 32'd1, 32'd0);
                end else begin
                    e = exp_q0.pop_front();
                    c = cyc_q0.pop_front();
                    check("r0_rdata", r0_rsp_rdata, e[31:0]);
                    check("r0_err", {31'd0, r0_rsp_err}, {31'd0, e[32]});
                    check("r0_latency", cycle, c + 1);
                end
            end
            if (r1_rsp_valid) begin
                if (exp_q1.size() == 0) begin
                    check("r1_unexpected_rsp", 32'd1, 32'd0);
                end else begin
                    e = exp_q1.pop_front();
                    c = cyc_q1.pop_front();
                    check("r1_rdata", r1_rsp_rdata, e[31:0]);
                    check("r1_err", {31'd0, r1_rsp_err}, {31'd0, e[32]});
                    check("r1_latency", cycle, c + 1);
                end
            end
        end
    end

    // Driver: called just after a rising edge; returns just after the accepting edge.
    task automatic access(input int port, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] mask, input logic lock,
                          input logic [31:0] exp_rdata, input logic exp_err);
        bit got = 1'b0;
        if (port == 0) begin
            r0_valid = 1'b1; r0_addr = addr; r0_wdata = wdata; r0_wmask = mask; r0_lock = lock;
        end else begin
            r1_valid = 1'b1; r1_addr = addr; r1_wdata = wdata; r1_wmask = mask; r1_lock = lock;
        end
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if ((port == 0) ? r0_ready : r1_ready) begin
                if (port == 0) begin
                    exp_q0.push_back({exp_err, exp_rdata});
                    cyc_q0.push_back(cycle);
                end else begin
                    exp_q1.push_back({exp_err, exp_rdata});
                    cyc_q1.push_back(cycle);
                end
                got = 1'b1;
                break;
            end
        end
        if (!got) check($sformatf("r%0d_grant_timeout", port), 32'd0, 32'd1);
        @(posedge clk);
        #1;
        if (port == 0) r0_valid = 1'b0;
        else           r1_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        r0_valid = 0; r0_addr = 0; r0_wdata = 0; r0_wmask = 0; r0_lock = 0;
        r1_valid = 0; r1_addr = 0; r1_wdata = 0; r1_wmask = 0; r1_lock = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_r0_rsp_valid", {31'd0, r0_rsp_valid}, 32'd0);
        check("rst_r1_rsp_rdata", r1_rsp_rdata, 32'd0);
        rst_n = 1'b1;

        // Idle after reset
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("idle_ready", {30'd0, r0_ready, r1_ready}, 32'd0);
            check("idle_wmask", {28'd0, mem_wmask}, 32'd0);
            check("idle_rsp_valid", {30'd0, r0_rsp_valid, r1_rsp_valid}, 32'd0);
            check("idle_state", {30'd0, dbg_state}, 32'd0);
        end
        @(posedge clk); #1;

        // Basic write / readback on r0
        access(0, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0, 32'h0, 1'b0);
        access(0, 32'h10, 32'h0, 4'h0, 1'b0, 32'hDEADBEEF, 1'b0);

        // Byte-masked write on r1
        access(1, 32'h20, 32'hFFFFFFFF, 4'hF, 1'b0, 32'h0, 1'b0);
        access(1, 32'h20, 32'h00AB0000, 4'b0100, 1'b0, 32'h0, 1'b0);
        access(1, 32'h20, 32'h0, 4'h0, 1'b0, 32'hFFABFFFF, 1'b0);
        access(1, 32'h30, 32'h00000005, 4'hF, 1'b0, 32'h0, 1'b0);

        // Both requesting continuously: grants alternate starting with r0
        log_en = 1'b1;
        fork
            for (int i = 0; i < 4; i++) access(0, 32'h10, 32'h0, 4'h0, 1'b0, 32'hDEADBEEF, 1'b0);
            for (int i = 0; i < 4; i++) access(1, 32'h20, 32'h0, 4'h0, 1'b0, 32'hFFABFFFF, 1'b0);
        join
        log_en = 1'b0;
        check("alt_count", grant_log.size(), 32'd8);
        for (int i = 0; i < grant_log.size(); i++) check($sformatf("alt_grant%0d", i), grant_log[i], i % 2);
        grant_log.delete();

        // Locked read-modify-write on r0 while r1 waits
        log_en = 1'b1;
        fork
            begin
                access(0, 32'h30, 32'h0, 4'h0, 1'b1, 32'h00000005, 1'b0);
                access(0, 32'h30, 32'h12345678, 4'hF, 1'b1, 32'h0, 1'b0);
                access(0, 32'h30, 32'h0, 4'h0, 1'b1, 32'h12345678, 1'b0);
                access(0, 32'h30, 32'h9ABCDEF0, 4'hF, 1'b0, 32'h0, 1'b0);
            end
            access(1, 32'h30, 32'h0, 4'h0, 1'b0, 32'h9ABCDEF0, 1'b0);
        join
        log_en = 1'b0;
        check("lock_count", grant_log.size(), 32'd5);
        for (int i = 0; i < grant_log.size(); i++)
            check($sformatf("lock_grant%0d", i), grant_log[i], (i == 4) ? 1 : 0);
        grant_log.delete();

        // Out-of-range: word 8192 aliases word 0 in the low bits and must not write it
        access(0, 32'h0, 32'h11111111, 4'hF, 1'b0, 32'h0, 1'b0);
        access(0, 32'h00008000, 32'h55555555, 4'hF, 1'b1, 32'h0, 1'b1);
        @(negedge clk);
        check("oor_no_lock", {30'd0, dbg_state}, 32'd0);
        @(posedge clk); #1;
        access(0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h11111111, 1'b0);
        access(1, 32'h7FE0, 32'h0, 4'h0, 1'b0, 32'h0, 1'b1);
        access(1, 32'h7FDC, 32'hA5A5A5A5, 4'hF, 1'b0, 32'h0, 1'b0);
        access(1, 32'h7FDC, 32'h0, 4'h0, 1'b0, 32'hA5A5A5A5, 1'b0);

        // Lock held with r0 idle, then reset mid-lock
        access(0, 32'h10, 32'h0, 4'h0, 1'b1, 32'hDEADBEEF, 1'b0);
        r1_valid = 1'b1; r1_addr = 32'h10; r1_wdata = 32'h0; r1_wmask = 4'h0; r1_lock = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("lock_hold_r1_ready", {31'd0, r1_ready}, 32'd0);
            check("lock_hold_state", {30'd0, dbg_state}, 32'd1);
            check("lock_hold_wmask", {28'd0, mem_wmask}, 32'd0);
        end
        @(posedge clk); #1;
        access(0, 32'h40, 32'hCAFEF00D, 4'hF, 1'b1, 32'h0, 1'b0);
        rst_n = 1'b0;
        exp_q0.delete();
        cyc_q0.delete();
        @(negedge clk);
        check("rst_drop_rsp", {31'd0, r0_rsp_valid}, 32'd0);
        check("rst_state", {30'd0, dbg_state}, 32'd0);
        r1_valid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        access(1, 32'h40, 32'h0, 4'h0, 1'b0, 32'hCAFEF00D, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        check("q0_drained", exp_q0.size(), 32'd0);
        check("q1_drained", exp_q1.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
